// File: rtl/register_16.sv
// -----------------------------------------------------------------------------
// register_16
//   Word-wide storage register with synchronous load enable and asynchronous,
//   active-high clear. Basic state element of the CPU datapath (A/D registers,
//   PC base, RAM cells). Each bit is a hold/load 2:1 mux feeding a rising-edge
//   D flip-flop with async clear, generated WIDTH times.
//
// Ports
//   clk    in   1      system clock, rising edge only
//   rst    in   1      async active-high clear of the stored word
//   in     in   WIDTH  word to capture
//   load   in   1      1 = capture in on next rising edge, 0 = hold
//   out    out  WIDTH  stored word, driven straight from the flops
// -----------------------------------------------------------------------------

// 2:1 mux primitive: sel=0 picks a, sel=1 picks b.
module register_16_mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    always_comb begin
        y = a;
        if (sel) begin
            y = b;
        end
    end
endmodule

// Rising-edge D flip-flop with asynchronous active-high clear.
module register_16_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;
endmodule

module register_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Hold path feeds each flop's own output back, so all bits share a single
    // load enable and there is never a combinational path from in to out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register_16_mux2 u_mux (
            .a   (out_q[i]),
            .b   (in[i]),
            .sel (load),
            .y   (out_d[i])
        );

        register_16_dff u_dff (
            .clk (clk),
            .rst (rst),
            .d   (out_d[i]),
            .q   (out_q[i])
        );
    end

    assign out = out_q;
endmodule

// File: tb/tb_register_16.sv
module tb_register_16;
    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [15:0] in;
    logic        load;
    logic [15:0] out;

    // Reference: the word the register should hold right now.
    logic [15:0] model_val;

    int n_cmp;
    int n_err;

    register_16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .load (load),
        .out  (out)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Rising edge: apply the storage rules to the reference, then check after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_val = 16'h0000;
        else if (load) model_val = in;
        #1;
        chk(tag, out, model_val);
    endtask

    task automatic drive(input logic r, input logic l, input logic [15:0] d);
        @(negedge clk);
        rst  = r;
        load = l;
        in   = d;
        if (r) model_val = 16'h0000;
    endtask

    logic [15:0] seq_vals [4];
    logic [15:0] bit_vals [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        clk_en = 1'b0;
        rst = 1'b0;
        load = 1'b1;
        in = 16'hffff;
        model_val = 16'h0000;
        seq_vals = '{16'h0030, 16'h2000, 16'h0070, 16'h0000};
        bit_vals = '{16'h0001, 16'h8000, 16'h5555, 16'haaaa};

        // 1: reset with clock idle clears at once, and holds through edges
        #3;
        rst = 1'b1;
        #1;
        chk("rst_idle", out, 16'h0000);
        clk_en = 1'b1;
        repeat (3) tick("rst_hold");

        // 2: load, no change before the edge, no transparency mid-cycle
        drive(1'b0, 1'b1, 16'ha000);
        #1;
        chk("pre_edge", out, 16'h0000);
        tick("load_a000");
        @(negedge clk);
        in = 16'h0a00;
        #1;
        chk("mid_cycle", out, 16'ha000);
        tick("load_0a00");

        // 3: hold
        drive(1'b0, 1'b1, 16'h000c);
        tick("load_000c");
        drive(1'b0, 1'b0, 16'h0d00);
        tick("hold_1");
        drive(1'b0, 1'b0, 16'he000);
        tick("hold_2");
        chk("hold_val", out, 16'h000c);

        // 4: one value per edge
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, seq_vals[i]);
            tick("seq");
        end
        chk("seq_last", out, 16'h0070);

        // 5: async reset mid-cycle while clk is high
        drive(1'b0, 1'b1, 16'hffff);
        tick("load_ffff");
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_val = 16'h0000;
        #1;
        chk("rst_async", out, 16'h0000);
        drive(1'b0, 1'b1, 16'h1234);
        tick("post_rst");

        // 6: input change while clk high only lands on the next rising edge
        @(posedge clk);
        #1;
        in = 16'h4321;
        load = 1'b1;
        #1;
        chk("clk_high", out, 16'h1234);
        @(negedge clk);
        #1;
        chk("fall_edge", out, 16'h1234);
        tick("rise_4321");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, bit_vals[i]);
            tick("bit_indep");
        end

        // Randomized traffic, including occasional async resets
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, 16'($urandom));
            #1;
            chk("rand_mid", out, model_val);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
